// File: rtl/xs3_codec_seq.sv
// Iterative multi-digit BCD <-> excess-3 converter.
// Takes one packed word over valid/ready, converts one nibble per clock,
// flags digits outside the selected code, and holds the result on a
// valid/ready output until it is consumed.

// Single-digit converter: +3 (BCD->XS3) or -3 (XS3->BCD).
// An illegal digit passes through unchanged and raises bad.
module xs3_digit (
  input  logic       mode,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       bad
);
  // Legality check and +/-3 per direction.
  always_comb begin
    bad = 1'b0;
    q   = d;
    if (!mode) begin
      bad = (d > 4'd9);
      if (!bad) q = d + 4'd3;
    end else begin
      bad = (d < 4'd3) || (d > 4'd12);
      if (!bad) q = d - 4'd3;
    end
  end
endmodule

module xs3_codec_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic [DIGITS-1:0]     err,
  output logic                  err_any
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] din_q;
  logic                mode_q;
  logic [3:0]          dig, cq;
  logic                cbad;
  logic                last;

  // The word is walked one nibble at a time through a single converter.
  assign dig  = din_q[{idx, 2'b00} +: 4];
  assign last = (idx == IW'(DIGITS - 1));

  xs3_digit u_digit (
    .mode (mode_q),
    .d    (dig),
    .q    (cq),
    .bad  (cbad)
  );

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, fill one result digit per CONV cycle,
  // hold everything untouched while DONE waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      din_q   <= '0;
      mode_q  <= 1'b0;
      dout    <= '0;
      err     <= '0;
      err_any <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          din_q   <= din;
          mode_q  <= mode;
          idx     <= '0;
          dout    <= '0;
          err     <= '0;
          err_any <= 1'b0;
        end
        CONV: begin
          dout[{idx, 2'b00} +: 4] <= cq;
          err[idx]                <= cbad;
          err_any                 <= err_any | cbad;
          idx                     <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xs3_codec_seq.sv
// Directed bench for xs3_codec_seq (DIGITS=4).
module tb_xs3_codec_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [15:0] din = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] dout;
  logic [3:0]  err;
  logic        err_any;

  int checks = 0;
  int fails  = 0;

  xs3_codec_seq #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err),
    .err_any   (err_any)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word (waits, bounded, for in_ready), then scrambles din/mode
  // and returns the number of edges from accept to out_valid (99 = timeout).
  task automatic run_word(input logic m, input logic [15:0] d, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    mode = m; din = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mode = ~m; din = 16'hFFFF;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) lat = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (dout !== 16'h0)     begin fails++; $display("FAIL rst_dout got %h want 0000", dout); end
    checks++; if (err !== 4'h0 || err_any !== 1'b0) begin fails++; $display("FAIL rst_err got %b/%b want 0000/0", err, err_any); end
  endtask

  task automatic test_bcd2xs3();
    int lat;
    out_ready = 1'b1;
    run_word(1'b0, 16'h1234, lat);
    checks++; if (lat !== 4)          begin fails++; $display("FAIL t1_latency got %0d want 4", lat); end
    checks++; if (dout !== 16'h4567)  begin fails++; $display("FAIL t1_dout got %h want 4567", dout); end
    checks++; if (err !== 4'b0000 || err_any !== 1'b0) begin fails++; $display("FAIL t1_err got %b/%b want 0000/0", err, err_any); end
    checks++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL t1_ready_done got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL t1_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    run_word(1'b0, 16'h9A05, lat);
    checks++; if (dout !== 16'hCA38)  begin fails++; $display("FAIL t2_dout got %h want CA38", dout); end
    checks++; if (err !== 4'b0100 || err_any !== 1'b1) begin fails++; $display("FAIL t2_err got %b/%b want 0100/1", err, err_any); end
    tick();
  endtask

  task automatic test_xs32bcd();
    int lat;
    run_word(1'b1, 16'h4567, lat);
    checks++; if (dout !== 16'h1234)  begin fails++; $display("FAIL t3a_dout got %h want 1234", dout); end
    checks++; if (err !== 4'b0000 || err_any !== 1'b0) begin fails++; $display("FAIL t3a_err got %b/%b want 0000/0", err, err_any); end
    tick();
    run_word(1'b1, 16'h2C3D, lat);
    checks++; if (dout !== 16'h290D)  begin fails++; $display("FAIL t3b_dout got %h want 290D", dout); end
    checks++; if (err !== 4'b1001 || err_any !== 1'b1) begin fails++; $display("FAIL t3b_err got %b/%b want 1001/1", err, err_any); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] junk [5] = '{16'h1111, 16'h2222, 16'h9999, 16'h0000, 16'h4567};
    out_ready = 1'b0;
    run_word(1'b0, 16'h0123, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; din = junk[i]; mode = i[0];
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hs%0d got vld=%b rdy=%b want 1/0", i, out_valid, in_ready); end
      checks++; if (dout !== 16'h3456 || err !== 4'b0000 || err_any !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got %h/%b/%b want 3456/0000/0", i, dout, err, err_any); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    run_word(1'b1, 16'h9876, lat);
    checks++; if (lat !== 4 || dout !== 16'h6543 || err !== 4'b0000) begin fails++; $display("FAIL bp_next got lat=%0d %h/%b want 4 6543/0000", lat, dout, err); end
    tick();
  endtask

  task automatic test_sweep();
    int lat;
    logic [3:0]  exp0 [16] = '{4'h3,4'h4,4'h5,4'h6,4'h7,4'h8,4'h9,4'hA,4'hB,4'hC,4'hA,4'hB,4'hC,4'hD,4'hE,4'hF};
    logic [3:0]  exp1 [16] = '{4'h0,4'h1,4'h2,4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8,4'h9,4'hD,4'hE,4'hF};
    logic [15:0] bad0 = 16'hFC00;
    logic [15:0] bad1 = 16'hE007;
    logic [15:0] ed;
    logic [3:0]  ee;
    logic        ea;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 16; v++) begin
        // Upper digits are 0: +3 -> 3 in mode 0, illegal (kept 0) in mode 1.
        if (m == 0) begin ed = {12'h333, exp0[v]}; ee = {3'b000, bad0[v]}; ea = bad0[v]; end
        else        begin ed = {12'h000, exp1[v]}; ee = {3'b111, bad1[v]}; ea = 1'b1; end
        run_word(m[0], {12'h000, 4'(v)}, lat);
        checks++; if (dout !== ed || err !== ee || err_any !== ea) begin
          fails++; $display("FAIL sweep_m%0d_v%0d got %h/%b/%b want %h/%b/%b", m, v, dout, err, err_any, ed, ee, ea);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int spurious = 0;
    while (!in_ready) tick();
    mode = 1'b0; din = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (dout !== 16'h0067) begin fails++; $display("FAIL mid_partial got %h want 0067", dout); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_hs got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    checks++; if (dout !== 16'h0 || err !== 4'h0 || err_any !== 1'b0) begin fails++; $display("FAIL mid_rst_data got %h/%b/%b want 0000/0000/0", dout, err, err_any); end
    for (int i = 0; i < 6; i++) begin tick(); if (out_valid) spurious++; end
    checks++; if (spurious !== 0) begin fails++; $display("FAIL mid_spurious got %0d want 0", spurious); end
    run_word(1'b0, 16'h0852, lat);
    checks++; if (lat !== 4 || dout !== 16'h3B85 || err !== 4'b0000) begin fails++; $display("FAIL mid_after got lat=%0d %h/%b want 4 3B85/0000", lat, dout, err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_bcd2xs3();
    test_xs32bcd();
    test_backpressure();
    test_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
